// File: rtl/eco32_core_mpu_cfr_ring.sv
`default_nettype none
// ============================================================================
// Module   : eco32_core_mpu_cfr_ring
// Purpose  : Condition-flag register ring for the barrel-threaded ECO32 core.
//            Holds one FW-bit flag word per hardware thread in an NTH-deep
//            circulating ring. One thread's word is presented per cycle,
//            together with that thread's id. Two write ports merge into the
//            word re-entering the ring:
//              port A : architectural masked overwrite, highest priority
//              port B : ALU/exception update; STICKY bits are OR-accumulated,
//                       other masked bits are overwritten
// Config   : `define ECO32_MPU_CFR_DBG_EN to build the debug strobe register
//            and the dbg_tid/dbg_flags outputs; otherwise they read as 0.
// Ports    : clk, rst (async, active-high)
//            ia_wen/ia_mask/ia_flags : port A write
//            ib_wen/ib_mask/ib_flags : port B write
//            o_flags, o_tid          : presented flag word and its owner
//            dbg_stb, dbg_tid,
//            dbg_flags               : debug change tracking
// Revision : 1.0 - initial parametrised release
// ============================================================================
module eco32_core_mpu_cfr_ring #(
    parameter int              FW     = 16,
    parameter int              NTH    = 2,
    parameter int              TW     = 1,
    parameter logic [FW-1:0]   STICKY = {FW{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ia_wen,
    input  logic [FW-1:0]   ia_mask,
    input  logic [FW-1:0]   ia_flags,
    input  logic            ib_wen,
    input  logic [FW-1:0]   ib_mask,
    input  logic [FW-1:0]   ib_flags,
    output logic [FW-1:0]   o_flags,
    output logic [TW-1:0]   o_tid,
    output logic            dbg_stb,
    output logic [TW-1:0]   dbg_tid,
    output logic [6:0]      dbg_flags
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if (FW < 10) begin : g_chk_fw
            $error("eco32_core_mpu_cfr_ring: FW must be >= 10");
        end
        if (NTH < 2) begin : g_chk_nth
            $error("eco32_core_mpu_cfr_ring: NTH must be >= 2");
        end
        if ((2 ** TW) < NTH) begin : g_chk_tw
            $error("eco32_core_mpu_cfr_ring: TW too narrow for NTH threads");
        end
    endgenerate

    localparam logic [TW-1:0] C_TID_LAST = TW'(NTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [FW-1:0] ring_q [NTH];
    logic [FW-1:0] ring_d [NTH];
    logic [TW-1:0] tid_q;
    logic [TW-1:0] tid_d;

    // Port-B and final merged values of the word re-entering the ring.
    logic [FW-1:0] w_base;
    logic [FW-1:0] w_b_val;
    logic [FW-1:0] w_b_merged;
    logic [FW-1:0] w_merged;

    // The last ring stage always holds the word of thread (o_tid+1) mod NTH,
    // so writes presented while o_tid == t land on thread t+1 and are seen
    // on o_flags one cycle later.
    assign w_base = ring_q[NTH-1];

    always_comb begin
        // Sticky bits accumulate; non-sticky bits take the new data.
        w_b_val    = (STICKY & (w_base | ib_flags)) | (~STICKY & ib_flags);
        w_b_merged = w_base;
        if (ib_wen) begin
            w_b_merged = (w_base & ~ib_mask) | (w_b_val & ib_mask);
        end
        // Port A overrides stickiness and port B on its masked bits.
        w_merged = w_b_merged;
        if (ia_wen) begin
            w_merged = (w_b_merged & ~ia_mask) | (ia_flags & ia_mask);
        end
    end

    always_comb begin
        for (int k = 0; k < NTH; k++) begin
            ring_d[k] = '0;
        end
        ring_d[0] = w_merged;
        for (int k = 1; k < NTH; k++) begin
            ring_d[k] = ring_q[k-1];
        end
        tid_d = (tid_q == C_TID_LAST) ? '0 : tid_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTH; k++) begin
                ring_q[k] <= '0;
            end
            tid_q <= '0;
        end else begin
            for (int k = 0; k < NTH; k++) begin
                ring_q[k] <= ring_d[k];
            end
            tid_q <= tid_d;
        end
    end

    assign o_flags = ring_q[0];
    assign o_tid   = tid_q;

    // ------------------------------------------------------------------------
    // Debug change tracking
    // ------------------------------------------------------------------------
`ifdef ECO32_MPU_CFR_DBG_EN
    logic dbg_stb_q;
    logic dbg_stb_d;

    // A zero-mask write still counts as a write here.
    assign dbg_stb_d = ia_wen | ib_wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_stb_q <= 1'b0;
        end else begin
            dbg_stb_q <= dbg_stb_d;
        end
    end

    assign dbg_stb   = dbg_stb_q;
    assign dbg_tid   = tid_q;
    assign dbg_flags = {ring_q[0][9:7], ring_q[0][3:0]};
`else
    assign dbg_stb   = 1'b0;
    assign dbg_tid   = '0;
    assign dbg_flags = 7'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eco32_core_mpu_cfr_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_eco32_core_mpu_cfr_ring
// Purpose  : Directed self-checking bench for eco32_core_mpu_cfr_ring
//            (NTH=4, FW=16, STICKY=0x0008).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eco32_core_mpu_cfr_ring;

    localparam int            FW     = 16;
    localparam int            NTH    = 4;
    localparam int            TW     = 2;
    localparam logic [15:0]   STICKY = 16'h0008;
`ifdef ECO32_MPU_CFR_DBG_EN
    localparam bit            DBG    = 1'b1;
`else
    localparam bit            DBG    = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            ia_wen;
    logic [FW-1:0]   ia_mask;
    logic [FW-1:0]   ia_flags;
    logic            ib_wen;
    logic [FW-1:0]   ib_mask;
    logic [FW-1:0]   ib_flags;
    logic [FW-1:0]   o_flags;
    logic [TW-1:0]   o_tid;
    logic            dbg_stb;
    logic [TW-1:0]   dbg_tid;
    logic [6:0]      dbg_flags;

    int n_checks;
    int n_errors;

    eco32_core_mpu_cfr_ring #(
        .FW     (FW),
        .NTH    (NTH),
        .TW     (TW),
        .STICKY (STICKY)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ia_wen    (ia_wen),
        .ia_mask   (ia_mask),
        .ia_flags  (ia_flags),
        .ib_wen    (ib_wen),
        .ib_mask   (ib_mask),
        .ib_flags  (ib_flags),
        .o_flags   (o_flags),
        .o_tid     (o_tid),
        .dbg_stb   (dbg_stb),
        .dbg_tid   (dbg_tid),
        .dbg_flags (dbg_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia_wen = 1'b0; ia_mask = '0; ia_flags = '0;
        ib_wen = 1'b0; ib_mask = '0; ib_flags = '0;
    endtask

    task automatic wait_tid(input logic [TW-1:0] t);
        for (int i = 0; i < 2 * NTH && o_tid != t; i++) tick();
        check("wait_tid", 32'(o_tid), 32'(t));
    endtask

    task automatic write_a(input logic [FW-1:0] m, input logic [FW-1:0] d);
        ia_wen = 1'b1; ia_mask = m; ia_flags = d;
        tick();
        idle_inputs();
    endtask

    task automatic write_b(input logic [FW-1:0] m, input logic [FW-1:0] d);
        ib_wen = 1'b1; ib_mask = m; ib_flags = d;
        tick();
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst = 1'b1;
        #2;
        check("rst_flags", 32'(o_flags), 32'h0);
        check("rst_tid",   32'(o_tid),   32'h0);
        check("rst_stb",   32'(dbg_stb), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Free run: tid walks 0..3, every thread reads zero, no strobe.
        for (int i = 0; i < 8; i++) begin
            check("run_tid",   32'(o_tid),   32'(i % NTH));
            check("run_flags", 32'(o_flags), 32'h0);
            check("run_stb",   32'(dbg_stb), 32'h0);
            tick();
        end

        // Port A full write while tid=0 lands on thread 1.
        wait_tid(2'd0);
        write_a(16'hFFFF, 16'h1234);
        check("a_tid",      32'(o_tid),     32'd1);
        check("a_flags",    32'(o_flags),   32'h1234);
        check("a_stb",      32'(dbg_stb),   DBG ? 32'd1 : 32'd0);
        check("a_dbg_tid",  32'(dbg_tid),   DBG ? 32'd1 : 32'd0);
        check("a_dbg_flg",  32'(dbg_flags), DBG ? 32'h44 : 32'h0);
        tick();
        check("a_th2",      32'(o_flags),   32'h0);
        check("a_stb_off",  32'(dbg_stb),   32'h0);
        tick();
        check("a_th3",      32'(o_flags),   32'h0);
        tick();
        check("a_th0",      32'(o_flags),   32'h0);
        tick();
        check("a_th1_again", 32'(o_flags),  32'h1234);
        check("a_tid_again", 32'(o_tid),    32'd1);

        // Sticky behaviour on thread 2 (written while tid=1).
        write_a(16'hFFFF, 16'h0008);
        check("s_seed",     32'(o_flags),   32'h0008);
        wait_tid(2'd1);
        write_b(16'hFFFF, 16'h0001);
        check("s_b_or",     32'(o_flags),   32'h0009);
        wait_tid(2'd1);
        write_a(16'h0008, 16'h0000);
        check("s_a_clear",  32'(o_flags),   32'h0001);
        wait_tid(2'd1);
        write_b(16'hFFFF, 16'h0000);
        check("s_b_nonst",  32'(o_flags),   32'h0000);
        wait_tid(2'd1);
        write_b(16'h0000, 16'hFFFF);
        check("s_b_mask0",  32'(o_flags),   32'h0000);
        check("s_b_m0_stb", 32'(dbg_stb),   DBG ? 32'd1 : 32'd0);

        // Simultaneous A and B on thread 3 (written while tid=2).
        wait_tid(2'd2);
        ia_wen = 1'b1; ia_mask = 16'h00FF; ia_flags = 16'h00AA;
        ib_wen = 1'b1; ib_mask = 16'hFFFF; ib_flags = 16'h5555;
        tick();
        idle_inputs();
        check("ab_merge",   32'(o_flags),   32'h55AA);
        check("ab_tid",     32'(o_tid),     32'd3);
        tick();
        check("ab_th0",     32'(o_flags),   32'h0);
        tick();
        check("ab_th1",     32'(o_flags),   32'h1234);

        // Reset in the middle of a write: cleared at once, write discarded.
        wait_tid(2'd0);
        ia_wen = 1'b1; ia_mask = 16'hFFFF; ia_flags = 16'hBEEF;
        #2 rst = 1'b1;
        #1;
        check("mr_flags",   32'(o_flags),   32'h0);
        check("mr_tid",     32'(o_tid),     32'h0);
        check("mr_stb",     32'(dbg_stb),   32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 2 * NTH; i++) begin
            check("post_rst_tid",   32'(o_tid),   32'(i % NTH));
            check("post_rst_flags", 32'(o_flags), 32'h0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
